// File: rtl/pico_sim_pkg.sv
// rtl/pico_sim_pkg.sv - shared constants, field offsets and FSM state for pico_sim
package pico_sim_pkg;

  localparam int BASE_W          = 2;
  localparam int MAX_REF_BASES   = 1024;
  localparam int MAX_QUERY_BASES = 64;
  localparam int STREAM_W        = 128;
  localparam int REF_WORD_W      = 256;
  localparam int REF_WORDS       = MAX_REF_BASES * BASE_W / REF_WORD_W;
  localparam int REF_BITS        = MAX_REF_BASES * BASE_W;

  localparam int HDR_REF_LEN_LSB   = 96;
  localparam int HDR_QUERY_LEN_LSB = 64;
  localparam int HDR_QUERY_ID_LSB  = 32;
  localparam int HDR_MAX_MM_LSB    = 0;

  localparam int RES_MM_LSB  = 48;
  localparam int RES_ID_LSB  = 32;
  localparam int RES_LOC_LSB = 0;

  localparam logic [31:0] DONE_LOC = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_QUERY,
    ST_SCAN,
    ST_EMIT,
    ST_DONE
  } state_t;

  // Hit and done words share one layout; only the meaning of the count field differs.
  function automatic logic [STREAM_W-1:0] result_word(
    input logic [15:0] count,
    input logic [15:0] id,
    input logic [31:0] loc
  );
    logic [STREAM_W-1:0] w;
    w = '0;
    w[RES_MM_LSB +: 16]  = count;
    w[RES_ID_LSB +: 16]  = id;
    w[RES_LOC_LSB +: 32] = loc;
    return w;
  endfunction

endpackage

// File: rtl/pico_sim_mismatch_counter.sv
// rtl/pico_sim_mismatch_counter.sv - masked 64-base compare with popcount
module mismatch_counter
  import pico_sim_pkg::*;
(
  input  logic [STREAM_W-1:0] query,
  input  logic [STREAM_W-1:0] window,
  input  logic [6:0]          query_len,
  output logic [6:0]          mm
);

  always_comb begin
    mm = '0;
    for (int i = 0; i < MAX_QUERY_BASES; i++) begin
      if ((7'(i) < query_len) && (query[BASE_W*i +: BASE_W] != window[BASE_W*i +: BASE_W]))
        mm = mm + 7'd1;
    end
  end

endmodule

// File: rtl/pico_sim.sv
// rtl/pico_sim.sv - single-channel ungapped sequence-search engine
module pico_sim
  import pico_sim_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ref_we,
  input  logic [2:0]            ref_addr,
  input  logic [REF_WORD_W-1:0] ref_wdata,
  input  logic                  s_in_valid,
  output logic                  s_in_rdy,
  input  logic [STREAM_W-1:0]   s_in_data,
  output logic                  s_out_valid,
  input  logic                  s_out_rdy,
  output logic [STREAM_W-1:0]   s_out_data
);

  state_t state, state_next;

  logic [REF_WORD_W-1:0] ref_mem [REF_WORDS];
  logic [REF_BITS-1:0]   scan_sr;
  logic [STREAM_W-1:0]   query_q;

  logic [10:0] ref_len_q;
  logic [31:0] query_len_q;
  logic [15:0] query_id_q;
  logic [31:0] max_mm_q;
  logic [10:0] loc_q;
  logic [15:0] hit_count_q;

  logic        in_fire, out_fire;
  logic        degenerate, is_last, hit;
  logic [6:0]  mm;
  logic [10:0] last_loc;
  logic [31:0] hdr_ref_len;
  logic [10:0] ref_len_clamped;
  logic        capture_hdr, capture_query, load_hit, load_done, advance;

  assign s_in_rdy  = (state == ST_IDLE) || (state == ST_QUERY);
  assign in_fire   = s_in_valid & s_in_rdy;
  assign out_fire  = s_out_valid & s_out_rdy;

  assign hdr_ref_len     = s_in_data[HDR_REF_LEN_LSB +: 32];
  assign ref_len_clamped = (hdr_ref_len > 32'(MAX_REF_BASES)) ? 11'(MAX_REF_BASES) : hdr_ref_len[10:0];

  assign degenerate = (query_len_q == 32'd0) || (query_len_q > 32'(MAX_QUERY_BASES)) ||
                      (query_len_q > {21'd0, ref_len_q});
  assign last_loc   = ref_len_q - {4'd0, query_len_q[6:0]};
  assign is_last    = (loc_q == last_loc);
  assign hit        = ({25'd0, mm} <= max_mm_q);

  // The scan window is always the low 64 bases of the shifted snapshot.
  mismatch_counter u_mismatch_counter (
    .query     (query_q),
    .window    (scan_sr[STREAM_W-1:0]),
    .query_len (query_len_q[6:0]),
    .mm        (mm)
  );

  always_ff @(posedge clk) begin
    if (ref_we)
      ref_mem[ref_addr] <= ref_wdata;
  end

  // Reads ref_mem before any same-cycle write lands, so a colliding write is excluded.
  always_ff @(posedge clk) begin
    if (capture_query) begin
      scan_sr <= {ref_mem[7], ref_mem[6], ref_mem[5], ref_mem[4],
                  ref_mem[3], ref_mem[2], ref_mem[1], ref_mem[0]};
      query_q <= s_in_data;
    end else if (advance) begin
      scan_sr <= {{BASE_W{1'b0}}, scan_sr[REF_BITS-1:BASE_W]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      s_out_valid <= 1'b0;
      s_out_data  <= '0;
      hit_count_q <= '0;
      loc_q       <= '0;
      ref_len_q   <= '0;
      query_len_q <= '0;
      query_id_q  <= '0;
      max_mm_q    <= '0;
    end else begin
      state <= state_next;
      if (capture_hdr) begin
        ref_len_q   <= ref_len_clamped;
        query_len_q <= s_in_data[HDR_QUERY_LEN_LSB +: 32];
        query_id_q  <= s_in_data[HDR_QUERY_ID_LSB +: 16];
        max_mm_q    <= s_in_data[HDR_MAX_MM_LSB +: 32];
        hit_count_q <= '0;
      end
      if (capture_query)
        loc_q <= '0;
      else if (advance)
        loc_q <= loc_q + 11'd1;
      if (load_hit) begin
        s_out_data  <= result_word({9'd0, mm}, query_id_q, {21'd0, loc_q});
        hit_count_q <= (hit_count_q == 16'hFFFF) ? hit_count_q : hit_count_q + 16'd1;
      end else if (load_done) begin
        s_out_data  <= result_word(hit_count_q, query_id_q, DONE_LOC);
      end
      if (load_hit || load_done)
        s_out_valid <= 1'b1;
      else if (out_fire)
        s_out_valid <= 1'b0;
    end
  end

  always_comb begin
    state_next    = state;
    capture_hdr   = 1'b0;
    capture_query = 1'b0;
    load_hit      = 1'b0;
    load_done     = 1'b0;
    advance       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_fire) begin
          capture_hdr = 1'b1;
          state_next  = ST_QUERY;
        end
      end
      ST_QUERY: begin
        if (in_fire) begin
          if (degenerate) begin
            load_done  = 1'b1;
            state_next = ST_DONE;
          end else begin
            capture_query = 1'b1;
            state_next    = ST_SCAN;
          end
        end
      end
      ST_SCAN: begin
        if (hit) begin
          load_hit   = 1'b1;
          state_next = ST_EMIT;
        end else if (is_last) begin
          load_done  = 1'b1;
          state_next = ST_DONE;
        end else begin
          advance = 1'b1;
        end
      end
      ST_EMIT: begin
        if (out_fire) begin
          if (is_last) begin
            load_done  = 1'b1;
            state_next = ST_DONE;
          end else begin
            advance    = 1'b1;
            state_next = ST_SCAN;
          end
        end
      end
      ST_DONE: begin
        if (out_fire)
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pico_sim.sv
// tb/tb_pico_sim.sv - directed self-checking bench for pico_sim
module tb_pico_sim;

  logic         clk = 1'b0;
  logic         rst;
  logic         ref_we;
  logic [2:0]   ref_addr;
  logic [255:0] ref_wdata;
  logic         s_in_valid;
  logic         s_in_rdy;
  logic [127:0] s_in_data;
  logic         s_out_valid;
  logic         s_out_rdy;
  logic [127:0] s_out_data;

  localparam logic [127:0] Q = 128'hc8facaa7c280aa28a020aaaf89aae004;
  localparam logic [31:0]  DL = 32'hFFFF_FFFF;

  int n_checks = 0;
  int n_fails  = 0;
  logic [2047:0] ref_img;
  logic [127:0]  got[$];

  pico_sim dut (
    .clk         (clk),
    .rst         (rst),
    .ref_we      (ref_we),
    .ref_addr    (ref_addr),
    .ref_wdata   (ref_wdata),
    .s_in_valid  (s_in_valid),
    .s_in_rdy    (s_in_rdy),
    .s_in_data   (s_in_data),
    .s_out_valid (s_out_valid),
    .s_out_rdy   (s_out_rdy),
    .s_out_data  (s_out_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_ref_word(input int a, input logic [255:0] d);
    ref_we = 1'b1; ref_addr = 3'(a); ref_wdata = d;
    tick();
    ref_we = 1'b0;
  endtask

  task automatic load_ref();
    for (int w = 0; w < 8; w++) write_ref_word(w, ref_img[256*w +: 256]);
  endtask

  task automatic send_word(input logic [127:0] w, output bit ok);
    s_in_data = w; s_in_valid = 1'b1; ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      if (s_in_rdy === 1'b1) ok = 1'b1;
      tick();
    end
    s_in_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [31:0] rl, input logic [31:0] ql, input logic [31:0] id,
                          input logic [31:0] mmx, input bit collide);
    bit ok;
    send_word({rl, ql, id, mmx}, ok);
    n_checks++;
    if (!ok) begin n_fails++; $display("FAIL header_accept: got timeout, required accept"); end
    if (collide) begin ref_we = 1'b1; ref_addr = 3'd1; ref_wdata = '0; end
    send_word(Q, ok);
    ref_we = 1'b0;
    n_checks++;
    if (!ok) begin n_fails++; $display("FAIL query_accept: got timeout, required accept"); end
  endtask

  task automatic get_word(output logic [127:0] w, output bit ok);
    ok = 1'b0; w = '0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      if (s_out_valid === 1'b1 && s_out_rdy === 1'b1) begin ok = 1'b1; w = s_out_data; end
      tick();
    end
  endtask

  task automatic collect_all();
    logic [127:0] w;
    bit wok, done;
    got.delete();
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      get_word(w, wok);
      if (!wok) break;
      got.push_back(w);
      if (w[31:0] == DL) done = 1'b1;
    end
    n_checks++;
    if (!done) begin n_fails++; $display("FAIL done_word_seen: got %0d words without done", got.size()); end
  endtask

  function automatic logic [127:0] word_at(input int k);
    return (k < got.size()) ? got[k] : {128{1'bx}};
  endfunction

  task automatic test_reset();
    rst = 1'b1; ref_we = 1'b0; ref_addr = '0; ref_wdata = '0;
    s_in_valid = 1'b0; s_in_data = '0; s_out_rdy = 1'b1;
    tick(); tick();
    n_checks += 3;
    if (s_out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid: got %b required 0", s_out_valid); end
    if (s_out_data !== '0) begin n_fails++; $display("FAIL reset_data: got %h required 0", s_out_data); end
    if (s_in_rdy !== 1'b1) begin n_fails++; $display("FAIL reset_rdy: got %b required 1", s_in_rdy); end
    rst = 1'b0;
    tick();
    n_checks++;
    if (s_in_rdy !== 1'b1) begin n_fails++; $display("FAIL idle_rdy: got %b required 1", s_in_rdy); end
  endtask

  task automatic test_exact_match();
    ref_img = '0;
    ref_img[400 +: 128] = Q;
    load_ref();
    send_cmd(32'h400, 32'h40, 32'd5, 32'd0, 1'b0);
    n_checks++;
    if (s_in_rdy !== 1'b0) begin n_fails++; $display("FAIL scan_rdy: got %b required 0", s_in_rdy); end
    collect_all();
    n_checks += 3;
    if (got.size() != 2) begin n_fails++; $display("FAIL exact_count: got %0d words required 2", got.size()); end
    if (word_at(0) !== {64'd0, 16'd0, 16'd5, 32'd200}) begin n_fails++; $display("FAIL exact_hit: got %h required %h", word_at(0), {64'd0, 16'd0, 16'd5, 32'd200}); end
    if (word_at(1) !== {64'd0, 16'd1, 16'd5, DL}) begin n_fails++; $display("FAIL exact_done: got %h required %h", word_at(1), {64'd0, 16'd1, 16'd5, DL}); end
    n_checks++;
    if (s_in_rdy !== 1'b1) begin n_fails++; $display("FAIL post_done_rdy: got %b required 1", s_in_rdy); end
    // ref_len beyond capacity clamps to 1024 rather than wrapping
    send_cmd(32'h0001_0000, 32'h40, 32'd6, 32'd0, 1'b0);
    collect_all();
    n_checks += 2;
    if (word_at(0) !== {64'd0, 16'd0, 16'd6, 32'd200}) begin n_fails++; $display("FAIL clamp_hit: got %h required %h", word_at(0), {64'd0, 16'd0, 16'd6, 32'd200}); end
    if (word_at(1) !== {64'd0, 16'd1, 16'd6, DL}) begin n_fails++; $display("FAIL clamp_done: got %h required %h", word_at(1), {64'd0, 16'd1, 16'd6, DL}); end
  endtask

  task automatic test_threshold();
    // reference bases 0..127 are all zero and Q has 43 non-zero bases
    send_cmd(32'h80, 32'h40, 32'd9, 32'd64, 1'b0);
    collect_all();
    n_checks++;
    if (got.size() != 66) begin n_fails++; $display("FAIL thr_count: got %0d words required 66", got.size()); end
    for (int k = 0; k <= 64; k++) begin
      n_checks++;
      if (word_at(k) !== {64'd0, 16'd43, 16'd9, 32'(k)}) begin
        n_fails++; $display("FAIL thr_hit%0d: got %h required %h", k, word_at(k), {64'd0, 16'd43, 16'd9, 32'(k)});
      end
    end
    n_checks++;
    if (word_at(65) !== {64'd0, 16'd65, 16'd9, DL}) begin n_fails++; $display("FAIL thr_done: got %h required %h", word_at(65), {64'd0, 16'd65, 16'd9, DL}); end
  endtask

  task automatic test_degenerate();
    logic [31:0] rl [3] = '{32'h400, 32'd5, 32'h400};
    logic [31:0] ql [3] = '{32'h80, 32'd10, 32'd0};
    for (int v = 0; v < 3; v++) begin
      send_cmd(rl[v], ql[v], 32'(20 + v), 32'd64, 1'b0);
      collect_all();
      n_checks += 3;
      if (got.size() != 1) begin n_fails++; $display("FAIL degen%0d_count: got %0d words required 1", v, got.size()); end
      if (word_at(0) !== {64'd0, 16'd0, 16'(20 + v), DL}) begin n_fails++; $display("FAIL degen%0d_done: got %h required %h", v, word_at(0), {64'd0, 16'd0, 16'(20 + v), DL}); end
      if (s_in_rdy !== 1'b1) begin n_fails++; $display("FAIL degen%0d_idle: got %b required 1", v, s_in_rdy); end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] d0;
    bit seen;
    s_out_rdy = 1'b0;
    send_cmd(32'h400, 32'h40, 32'd7, 32'd0, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      if (s_out_valid === 1'b1) seen = 1'b1; else tick();
    end
    n_checks++;
    if (!seen) begin n_fails++; $display("FAIL bp_valid: got timeout required valid"); end
    d0 = s_out_data;
    n_checks++;
    if (d0 !== {64'd0, 16'd0, 16'd7, 32'd200}) begin n_fails++; $display("FAIL bp_hit: got %h required %h", d0, {64'd0, 16'd0, 16'd7, 32'd200}); end
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks += 2;
      if (s_out_valid !== 1'b1) begin n_fails++; $display("FAIL bp_hold_valid%0d: got %b required 1", c, s_out_valid); end
      if (s_out_data !== d0) begin n_fails++; $display("FAIL bp_hold_data%0d: got %h required %h", c, s_out_data, d0); end
    end
    s_out_rdy = 1'b1;
    collect_all();
    n_checks += 3;
    if (got.size() != 2) begin n_fails++; $display("FAIL bp_count: got %0d words required 2", got.size()); end
    if (word_at(0) !== d0) begin n_fails++; $display("FAIL bp_first: got %h required %h", word_at(0), d0); end
    if (word_at(1) !== {64'd0, 16'd1, 16'd7, DL}) begin n_fails++; $display("FAIL bp_done: got %h required %h", word_at(1), {64'd0, 16'd1, 16'd7, DL}); end
  endtask

  task automatic test_snapshot();
    // word 1 is zeroed both in the query-accept cycle and again mid-scan
    send_cmd(32'h400, 32'h40, 32'd11, 32'd0, 1'b1);
    repeat (5) tick();
    write_ref_word(1, '0);
    collect_all();
    n_checks += 2;
    if (word_at(0) !== {64'd0, 16'd0, 16'd11, 32'd200}) begin n_fails++; $display("FAIL snap_hit: got %h required %h", word_at(0), {64'd0, 16'd0, 16'd11, 32'd200}); end
    if (word_at(1) !== {64'd0, 16'd1, 16'd11, DL}) begin n_fails++; $display("FAIL snap_done: got %h required %h", word_at(1), {64'd0, 16'd1, 16'd11, DL}); end
    send_cmd(32'h400, 32'h40, 32'd12, 32'd0, 1'b0);
    collect_all();
    n_checks += 2;
    if (got.size() != 1) begin n_fails++; $display("FAIL snap_new_count: got %0d words required 1", got.size()); end
    if (word_at(0) !== {64'd0, 16'd0, 16'd12, DL}) begin n_fails++; $display("FAIL snap_new_done: got %h required %h", word_at(0), {64'd0, 16'd0, 16'd12, DL}); end
    load_ref();
  endtask

  task automatic test_reset_mid_scan();
    send_cmd(32'h400, 32'h40, 32'd13, 32'd0, 1'b0);
    repeat (20) tick();
    rst = 1'b1;
    #1;
    n_checks += 3;
    if (s_out_valid !== 1'b0) begin n_fails++; $display("FAIL midrst_valid: got %b required 0", s_out_valid); end
    if (s_in_rdy !== 1'b1) begin n_fails++; $display("FAIL midrst_rdy: got %b required 1", s_in_rdy); end
    if (s_out_data !== '0) begin n_fails++; $display("FAIL midrst_data: got %h required 0", s_out_data); end
    tick();
    rst = 1'b0;
    tick();
    send_cmd(32'h400, 32'h40, 32'd14, 32'd0, 1'b0);
    collect_all();
    n_checks += 3;
    if (got.size() != 2) begin n_fails++; $display("FAIL midrst_count: got %0d words required 2", got.size()); end
    if (word_at(0) !== {64'd0, 16'd0, 16'd14, 32'd200}) begin n_fails++; $display("FAIL midrst_hit: got %h required %h", word_at(0), {64'd0, 16'd0, 16'd14, 32'd200}); end
    if (word_at(1) !== {64'd0, 16'd1, 16'd14, DL}) begin n_fails++; $display("FAIL midrst_done: got %h required %h", word_at(1), {64'd0, 16'd1, 16'd14, DL}); end
  endtask

  initial begin
    test_reset();
    test_exact_match();
    test_threshold();
    test_degenerate();
    test_backpressure();
    test_snapshot();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pico_sim.md
# pico_sim

Single-channel ungapped sequence-search engine for the Smith-Waterman accelerator stream interface. It holds a reference of up to 1024 2-bit bases loaded through a write port. It accepts a two-word command (header, query) on a 128-bit input stream and scans every reference offset. It emits one result word per offset whose mismatch count is within threshold, then a done word.

## Interface
- `MAX_REF_BASES`, 1024: reference capacity in bases (8 × 256-bit words).
- `MAX_QUERY_BASES`, 64: query capacity in bases (one 128-bit word).
- `clk` in 1: sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `ref_we` in 1: reference write strobe.
- `ref_addr` in 3: reference word index.
- `ref_wdata` in 256: 128 bases; base i at bits [2i+1:2i].
- `s_in_valid` in 1: input stream word valid.
- `s_in_rdy` out 1: engine ready for an input word.
- `s_in_data` in 128: header or query word.
- `s_out_valid` out 1: result word valid.
- `s_out_rdy` in 1: consumer ready.
- `s_out_data` out 128: result word.

## Operation
- **Reference addressing:** global base n = word n/128, base n%128. Reference writes are accepted in any state.
- **Header word** fields:
  - [127:96] `ref_len` in bases, clamped to 1024.
  - [95:64] `query_len`.
  - [63:32] `query_id`, low 16 bits used.
  - [31:0] `max_mm`, the mismatch threshold.
- **Query word:** base i at [2i+1:2i]; only bases 0..query_len-1 are compared.
- **Snapshot:** on query-word accept, the 2048-bit reference is copied into a scan shift register. Later reference writes do not affect the running scan.
- **Scan:** offsets loc = 0 .. ref_len-query_len, ascending. mm(loc) = count of i < query_len with query[i] ≠ ref[loc+i].
- **Hit:** mm ≤ max_mm. A hit emits a hit word and increments `hit_count`.
- **Hit word:**
  - [127:64] = 0
  - [63:48] = mm
  - [47:32] = query_id
  - [31:0] = loc
- **Done word** (after the last offset):
  - [127:64] = 0
  - [63:48] = hit_count, saturating at 0xFFFF
  - [47:32] = query_id
  - [31:0] = 0xFFFF_FFFF
- **Degenerate command:** query_len = 0, query_len > 64, or query_len > ref_len → no scan; the done word only, with hit_count 0.
- **FSM:**
  - IDLE: accept header → QUERY.
  - QUERY: accept query → SCAN, or → DONE if degenerate.
  - SCAN: on a hit → EMIT; after the last offset → DONE; otherwise stay in SCAN.
  - EMIT: on out handshake → SCAN at the next offset, or → DONE if that was the last offset.
  - DONE: on out handshake → IDLE.

## Timing
- **Reset values:** `s_out_valid`=0, `s_out_data`=0, state IDLE, `s_in_rdy`=1 (combinational from state), hit_count=0. Reference storage is not reset.
- **Input side:** `s_in_rdy`=1 only in IDLE and QUERY. A word transfers on `s_in_valid & s_in_rdy`.
- **Scan rate:** the first offset is evaluated in the cycle after query accept. One offset per cycle while no output is pending; a hit costs at least one extra cycle.
- **Output side:** `s_out_data` is registered. `s_out_valid` and `s_out_data` are held stable until `s_out_rdy`, and `s_out_valid` is never dropped early.
- **Pipelining:** one command at a time; no header is accepted until the done word transfers. Back-to-back commands need no idle cycle after the done handshake.
- **Reset:** reset mid-scan or mid-emit aborts immediately; nothing further is emitted.
- **Write collision:** a reference write in the same cycle as query accept is NOT included in the snapshot.

## Structure
- **Shared package:** base encoding width (2), `MAX_REF_BASES`, `MAX_QUERY_BASES`, header and result field offsets, `DONE_LOC` = 32'hFFFF_FFFF, FSM state enum.
- **Sub-module:** `mismatch_counter` — combinational 64-base compare with query_len mask plus popcount, producing a 7-bit result.

## Test plan
- **Exact match:** reference = all base 0 except bases 200..263 = query 128'hc8facaa7c280aa28a020aaaf89aae004; header ref_len 0x400, query_len 0x40, id 5, max_mm 0 → hit {mm 0, id 5, loc 200}, then done {hit_count 1, id 5, loc FFFF_FFFF}.
- **Threshold:** same setup, max_mm 64, ref_len 0x80 → 65 hits, locs 0..64 ascending, then done with hit_count 65.
- **Degenerate:** query_len 0x80, or query_len > ref_len → only the done word, hit_count 0; the engine returns to IDLE.
- **Backpressure:** hold `s_out_rdy`=0 for 10 cycles at the first hit → data stable and valid held; no hit lost or duplicated.
- **Snapshot isolation:** rewrite `ref_addr` 1 during a scan → results match the pre-write reference; the next command sees the new data.
- **Reset mid-scan:** assert `rst` during SCAN → `s_out_valid`=0 and `s_in_rdy`=1 immediately; a subsequent command completes correctly.
